// File: rtl/mul_acc_seq_pkg.sv
// Shared constants and FSM state type for the sequential multiply-accumulate block.
package mul_acc_seq_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned LEN_W  = 4;

    // One-hot encoding so the status outputs decode from a single state bit.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ACC  = 3'b010,
        DONE = 3'b100
    } state_t;

endpackage : mul_acc_seq_pkg

// File: rtl/mul_acc_seq_sat_add.sv
// Signed ACC_W + PROD_W adder that clamps to the ACC_W two's-complement range.
module sat_add
    import mul_acc_seq_pkg::*;
#(
    parameter int unsigned ACC_W = 10
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  y,
    output logic              sat
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [EXT_W-1:0] a_ext;
    logic [EXT_W-1:0] b_ext;
    logic [EXT_W-1:0] sum_ext;

    assign a_ext   = {a[ACC_W-1], a};
    assign b_ext   = {{(EXT_W-PROD_W){b[PROD_W-1]}}, b};
    assign sum_ext = a_ext + b_ext;

    // The extra bit disagreeing with the ACC_W sign bit means the sum left the range.
    always_comb begin
        sat = sum_ext[EXT_W-1] ^ sum_ext[EXT_W-2];
        y   = sum_ext[ACC_W-1:0];
        if (sat) begin
            y = sum_ext[EXT_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule : sat_add

// File: rtl/mul_acc_seq.sv
// Sequential accumulator of signed products with saturation and a result handshake.
module mul_acc_seq
    import mul_acc_seq_pkg::*;
#(
    parameter int unsigned ACC_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_nxt;
    logic               ovf_q;
    logic               ovf_nxt;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   rem_nxt;
    logic [ACC_W-1:0]   sum_sat;
    logic               sum_clamped;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod),
        .y   (sum_sat),
        .sat (sum_clamped)
    );

    // Next-state, datapath updates and status outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_q;
        ovf_nxt   = ovf_q;
        rem_nxt   = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    rem_nxt   = len;
                    state_nxt = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_nxt = sum_sat;
                    ovf_nxt = ovf_q | sum_clamped;
                    rem_nxt = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc_q <= '0;
            ovf_q <= 1'b0;
            rem_q <= '0;
        end else begin
            state <= state_nxt;
            acc_q <= acc_nxt;
            ovf_q <= ovf_nxt;
            rem_q <= rem_nxt;
        end
    end

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule : mul_acc_seq

// File: tb/tb_mul_acc_seq.sv
// Directed self-checking bench for mul_acc_seq at ACC_W=10 and ACC_W=9.
module tb_mul_acc_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] prod;
    logic       out_ready;

    logic       in_ready10, out_valid10, ovf10, busy10;
    logic [9:0] acc10;
    logic       in_ready9, out_valid9, ovf9, busy9;
    logic [8:0] acc9;

    int n_tests;
    int n_fail;

    mul_acc_seq #(.ACC_W(10)) dut10 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .prod      (prod),
        .in_ready  (in_ready10),
        .out_ready (out_ready),
        .out_valid (out_valid10),
        .acc_out   (acc10),
        .ovf       (ovf10),
        .busy      (busy10)
    );

    mul_acc_seq #(.ACC_W(9)) dut9 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .prod      (prod),
        .in_ready  (in_ready9),
        .out_ready (out_ready),
        .out_valid (out_valid9),
        .acc_out   (acc9),
        .ovf       (ovf9),
        .busy      (busy9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int a10();
        return int'($signed(acc10));
    endfunction

    function automatic int a9();
        return int'($signed(acc9));
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        prod      = 8'd0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready10), 0);
        chk("rst_out_valid", int'(out_valid10), 0);
        chk("rst_busy", int'(busy10), 0);
        chk("rst_acc", a10(), 0);
        chk("rst_ovf", int'(ovf10), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy10), 0);

        // len=3, products 6, -8, 64 back to back
        start = 1'b1;
        len   = 4'd3;
        tick();
        start = 1'b0;
        chk("b2b_in_ready", int'(in_ready10), 1);
        chk("b2b_busy", int'(busy10), 1);
        chk("b2b_acc_cleared", a10(), 0);
        in_valid = 1'b1;
        prod = 8'(6);
        tick();
        chk("b2b_acc_1", a10(), 6);
        prod = 8'(-8);
        tick();
        chk("b2b_out_valid_early", int'(out_valid10), 0);
        prod = 8'(64);
        tick();
        in_valid = 1'b0;
        chk("b2b_out_valid", int'(out_valid10), 1);
        chk("b2b_in_ready_done", int'(in_ready10), 0);
        chk("b2b_acc", a10(), 62);
        chk("b2b_ovf", int'(ovf10), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_out_valid", int'(out_valid10), 0);
        chk("b2b_idle_busy", int'(busy10), 0);
        chk("b2b_idle_acc_hold", a10(), 62);

        // len=15 of 64 saturates positive
        start = 1'b1;
        len   = 4'd15;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        prod = 8'(64);
        repeat (15) tick();
        in_valid = 1'b0;
        chk("satp_out_valid", int'(out_valid10), 1);
        chk("satp_acc", a10(), 511);
        chk("satp_ovf", int'(ovf10), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("satp_idle_ovf_hold", int'(ovf10), 1);

        // Following run clears ovf
        start = 1'b1;
        len   = 4'd1;
        tick();
        start = 1'b0;
        chk("clr_ovf_at_start", int'(ovf10), 0);
        in_valid = 1'b1;
        prod = 8'(-8);
        tick();
        in_valid = 1'b0;
        chk("clr_out_valid", int'(out_valid10), 1);
        chk("clr_acc", a10(), -8);
        chk("clr_ovf", int'(ovf10), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // len=0 goes straight to DONE; start in DONE is ignored
        start = 1'b1;
        len   = 4'd0;
        tick();
        len   = 4'd5;
        chk("len0_out_valid", int'(out_valid10), 1);
        chk("len0_acc", a10(), 0);
        chk("len0_busy", int'(busy10), 1);
        tick();
        start = 1'b0;
        chk("len0_start_ignored_valid", int'(out_valid10), 1);
        chk("len0_start_ignored_ready", int'(in_ready10), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("len0_idle", int'(out_valid10), 0);

        // len=2 with gaps; DONE held by out_ready=0 while prod toggles
        start = 1'b1;
        len   = 4'd2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("gap_in_ready", int'(in_ready10), 1);
        chk("gap_acc_idle", a10(), 0);
        in_valid = 1'b1;
        prod = 8'(10);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("gap_out_valid_early", int'(out_valid10), 0);
        in_valid = 1'b1;
        prod = 8'(-3);
        tick();
        prod = 8'(50);
        for (int i = 0; i < 5; i++) begin
            chk("gap_done_valid", int'(out_valid10), 1);
            chk("gap_done_acc", a10(), 7);
            tick();
        end
        in_valid = 1'b0;
        chk("gap_done_still", int'(out_valid10), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("gap_idle_valid", int'(out_valid10), 0);
        chk("gap_idle_busy", int'(busy10), 0);
        chk("gap_idle_acc", a10(), 7);

        // Reset mid-run, then recover
        start = 1'b1;
        len   = 4'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        prod = 8'(20);
        tick();
        prod = 8'(30);
        tick();
        chk("mid_acc_before_rst", a10(), 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready10), 0);
        chk("mid_rst_busy", int'(busy10), 0);
        chk("mid_rst_acc", a10(), 0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_no_result", int'(out_valid10), 0);
            tick();
        end
        start = 1'b1;
        len   = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        prod = 8'(5);
        tick();
        in_valid = 1'b0;
        chk("mid_new_valid", int'(out_valid10), 1);
        chk("mid_new_acc", a10(), 5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Negative saturation at ACC_W=9; ACC_W=10 stays in range
        start = 1'b1;
        len   = 4'd9;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        prod = 8'(-56);
        repeat (9) tick();
        in_valid = 1'b0;
        chk("satn9_out_valid", int'(out_valid9), 1);
        chk("satn9_acc", a9(), -256);
        chk("satn9_ovf", int'(ovf9), 1);
        chk("satn10_acc", a10(), -504);
        chk("satn10_ovf", int'(ovf10), 0);

        // Reset beats out_ready and start on the same edge
        rst = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        len = 4'd3;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        chk("rstpri_in_ready", int'(in_ready9), 0);
        chk("rstpri_acc9", a9(), 0);
        chk("rstpri_ovf9", int'(ovf9), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mul_acc_seq

// File: doc/mul_acc_seq.md
MUL_ACC_SEQ -- requirements
Module: mul_acc_seq

Interface
REQ-001 Parameter ACC_W, default 10: accumulator width in bits, two's complement; legal range 9..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a new accumulation; sampled in IDLE only.
REQ-005 len  input  4  number of products to accumulate, unsigned 0..15; sampled with start.
REQ-006 in_valid  input  1  prod carries a valid product this cycle.
REQ-007 prod  input  8  signed product from the 4x4 signed multiplier stage; legal range -56..+64.
REQ-008 in_ready  output  1  block accepts prod this cycle.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_valid  output  1  acc_out and ovf hold a completed result.
REQ-011 acc_out  output  ACC_W  signed accumulated sum.
REQ-012 ovf  output  1  sticky flag; set if any addition in the current run saturated.
REQ-013 busy  output  1  high in ACC and DONE.

Function
REQ-014 FSM states: IDLE, ACC, DONE; state encoding is one-hot or binary, registered.
REQ-015 IDLE: in_ready=0, out_valid=0, busy=0; acc_out and ovf retain their last values.
REQ-016 IDLE with start=1 and len!=0: next cycle acc=0, ovf=0, remaining=len, state ACC.
REQ-017 IDLE with start=1 and len=0: next cycle acc=0, ovf=0, state DONE; no products are consumed.
REQ-018 ACC: in_ready=1 combinationally; a transfer occurs on any cycle with in_valid=1 while in ACC.
REQ-019 Per transfer: sum = acc + sign-extended prod, computed at ACC_W+1 bits; acc <= sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; remaining decrements by 1.
REQ-020 Saturation: if the clamp changes the value, ovf <= 1; ovf stays 1 until the next start.
REQ-021 A transfer with remaining=1 moves the state to DONE on the same edge; the final sum is visible on acc_out in the first DONE cycle.
REQ-022 ACC with in_valid=0: no state change; idle cycles between transfers are unbounded.
REQ-023 DONE: out_valid=1; acc_out and ovf stable; in_ready=0; prod is ignored.
REQ-024 DONE with out_ready=1: next cycle IDLE; out_valid=0.
REQ-025 start is ignored in ACC and DONE; len is not re-sampled.
REQ-026 Latency: one cycle from start to in_ready=1; one cycle from the last transfer to out_valid=1; throughput is 1 product per cycle.
REQ-027 acc_out is driven directly from the accumulator register (no combinational path from prod to acc_out).

Reset
REQ-028 rst=1 at a clock edge forces: state IDLE, acc_out=0, ovf=0, remaining=0, out_valid=0, in_ready=0, busy=0.
REQ-029 rst takes priority over start, in_valid and out_ready on the same edge.
REQ-030 rst mid-run (ACC or DONE) abandons the run; no result is presented afterwards.

Structure
REQ-031 Shared package holds the FSM state constants (IDLE/ACC/DONE), PROD_W=8 and LEN_W=4.
REQ-032 One sub-module, sat_add: signed ACC_W + 8-bit adder with clamp and a saturated flag; purely combinational.
REQ-033 The FSM, the remaining counter and the acc/ovf registers reside in mul_acc_seq.

Verification
REQ-034 Reset, then start with len=3, products 6, -8, 64 on back-to-back cycles -> out_valid after 4 cycles, acc_out=62, ovf=0.
REQ-035 len=15, all products 64, ACC_W=10 -> acc_out=511, ovf=1; the next run with len=1, prod=-8 -> acc_out=-8, ovf=0.
REQ-036 start with len=0 -> out_valid=1 next cycle, acc_out=0; start asserted again in DONE is ignored.
REQ-037 len=2 with in_valid gaps of 3 cycles and out_ready held 0 for 5 cycles -> acc_out stable in DONE; IDLE the cycle after out_ready=1.
REQ-038 rst asserted after 2 of 4 transfers -> state IDLE, acc_out=0, out_valid stays 0; a new run with len=1, prod=5 -> acc_out=5.
REQ-039 Negative saturation: ACC_W=9, len=9, all products -56 -> acc_out=-256, ovf=1.
